btn_event_arb: RTL

BTN_EVENT_ARB -- requirements
Module: btn_event_arb

---
 rtl/btn_event_arb.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/btn_event_arb.sv
// btn_event_arb: synchronises and debounces a bank of push buttons, turns
// debounced edges and long holds into events, and hands those events to a
// single consumer through a round-robin arbiter and a valid/ready register.
module btn_event_arb #(
    parameter int NUM_BTN    = 4,
    parameter int TICK_DIV   = 100000,
    parameter int SHIFT_LEN  = 8,
    parameter int LONG_TICKS = 250
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         btn_in,
    output logic [NUM_BTN-1:0]         btn_state,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic [1:0]                 evt_type,
    output logic                       evt_overflow,
    input  logic                       overflow_clr
);

    localparam int ID_W = $clog2(NUM_BTN);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int LC_W = $clog2(LONG_TICKS + 1);

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

    // Index of the k-th candidate after the last granted button, wrapping.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] last, input int k);
        int sum;
        sum = (int'(last) + k) % NUM_BTN;
        return ID_W'(sum);
    endfunction

    logic [NUM_BTN-1:0]   sync1_q;
    logic [NUM_BTN-1:0]   sync2_q;
    logic [PW-1:0]        presc_q;
    logic [PW-1:0]        presc_d;
    logic                 tick_s;
    logic [SHIFT_LEN-1:0] shreg_q [NUM_BTN];
    logic [SHIFT_LEN-1:0] shreg_d [NUM_BTN];
    logic [NUM_BTN-1:0]   state_q;
    logic [NUM_BTN-1:0]   state_d;
    logic [NUM_BTN-1:0]   prev_q;
    logic [LC_W-1:0]      lcnt_q [NUM_BTN];
    logic [LC_W-1:0]      lcnt_d [NUM_BTN];
    logic [NUM_BTN-1:0]   raise_s;
    logic [NUM_BTN-1:0]   collide_s;
    logic [1:0]           raise_type_s [NUM_BTN];
    logic [NUM_BTN-1:0]   slot_v_q;
    logic [NUM_BTN-1:0]   slot_v_d;
    logic [1:0]           slot_t_q [NUM_BTN];
    logic [1:0]           slot_t_d [NUM_BTN];
    logic                 load_s;
    logic                 grant_any_s;
    logic [ID_W-1:0]      grant_id_s;
    logic [NUM_BTN-1:0]   grant_sel_s;
    logic [NUM_BTN-1:0]   grant_vec_s;
    logic                 drop_s;
    logic                 evt_valid_q;
    logic                 evt_valid_d;
    logic [ID_W-1:0]      evt_id_q;
    logic [ID_W-1:0]      evt_id_d;
    logic [1:0]           evt_type_q;
    logic [1:0]           evt_type_d;
    logic [ID_W-1:0]      last_q;
    logic [ID_W-1:0]      last_d;
    logic                 ovf_q;
    logic                 ovf_d;

    assign btn_state    = state_q;
    assign evt_valid    = evt_valid_q;
    assign evt_id       = evt_id_q;
    assign evt_type     = evt_type_q;
    assign evt_overflow = ovf_q;

    // Shared sample tick: one cycle in every TICK_DIV.
    always_comb begin
        tick_s  = (presc_q == PW'(TICK_DIV - 1));
        presc_d = presc_q;
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Debounce sampling, level decision, long-hold counting and event raising.
    always_comb begin
        state_d   = state_q;
        raise_s   = '0;
        collide_s = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            shreg_d[i]      = shreg_q[i];
            lcnt_d[i]       = lcnt_q[i];
            raise_type_s[i] = EVT_NONE;

            if (tick_s) begin
                shreg_d[i] = {shreg_q[i][SHIFT_LEN-2:0], sync2_q[i]};
            end else begin
                shreg_d[i] = shreg_q[i];
            end

            if (&shreg_q[i]) begin
                state_d[i] = 1'b1;
            end else if (~|shreg_q[i]) begin
                state_d[i] = 1'b0;
            end else begin
                state_d[i] = state_q[i];
            end

            if (!state_q[i]) begin
                lcnt_d[i] = '0;
            end else if (tick_s && (lcnt_q[i] != LC_W'(LONG_TICKS))) begin
                lcnt_d[i] = lcnt_q[i] + LC_W'(1);
            end else begin
                lcnt_d[i] = lcnt_q[i];
            end

            // A press and a long-press can only coincide when LONG_TICKS is
            // tiny; the press wins the slot and the long-press counts as dropped.
            if (state_q[i] && !prev_q[i]) begin
                raise_s[i]      = 1'b1;
                raise_type_s[i] = EVT_PRESS;
                collide_s[i]    = tick_s && (lcnt_q[i] == LC_W'(LONG_TICKS - 1));
            end else if (!state_q[i] && prev_q[i]) begin
                raise_s[i]      = 1'b1;
                raise_type_s[i] = EVT_RELEASE;
            end else if (state_q[i] && tick_s && (lcnt_q[i] == LC_W'(LONG_TICKS - 1))) begin
                raise_s[i]      = 1'b1;
                raise_type_s[i] = EVT_LONG;
            end else begin
                raise_s[i]      = 1'b0;
                raise_type_s[i] = EVT_NONE;
            end
        end
    end

    // Round-robin pick among occupied slots, starting after the last grant.
    always_comb begin
        load_s      = !evt_valid_q || evt_ready;
        grant_any_s = 1'b0;
        grant_id_s  = '0;
        grant_sel_s = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            if (!grant_any_s && slot_v_q[rr_index(last_q, k)]) begin
                grant_any_s                     = 1'b1;
                grant_id_s                      = rr_index(last_q, k);
                grant_sel_s[rr_index(last_q, k)] = 1'b1;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        grant_vec_s = grant_sel_s & {NUM_BTN{load_s}};
    end

    // Output register, pending slots and overflow next-state.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_type_d  = evt_type_q;
        last_d      = last_q;
        slot_v_d    = slot_v_q;
        drop_s      = 1'b0;
        ovf_d       = ovf_q;

        if (load_s) begin
            evt_valid_d = grant_any_s;
            if (grant_any_s) begin
                evt_id_d   = grant_id_s;
                evt_type_d = slot_t_q[grant_id_s];
                last_d     = grant_id_s;
            end else begin
                evt_id_d   = evt_id_q;
                evt_type_d = evt_type_q;
            end
        end else begin
            evt_valid_d = evt_valid_q;
        end

        for (int i = 0; i < NUM_BTN; i++) begin
            slot_t_d[i] = slot_t_q[i];
            if (raise_s[i]) begin
                if (slot_v_q[i] && !grant_vec_s[i]) begin
                    drop_s = 1'b1;
                end else begin
                    slot_v_d[i] = 1'b1;
                    slot_t_d[i] = raise_type_s[i];
                end
                if (collide_s[i]) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_s;
                end
            end else if (grant_vec_s[i]) begin
                slot_v_d[i] = 1'b0;
                slot_t_d[i] = EVT_NONE;
            end else begin
                slot_v_d[i] = slot_v_q[i];
            end
        end

        if (overflow_clr) begin
            ovf_d = 1'b0;
        end else if (drop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Two-flop synchronizer on every raw button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Shared prescaler.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Per-button debounce history, level, previous level and long counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            prev_q  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                shreg_q[i] <= '0;
                lcnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            prev_q  <= state_q;
            for (int i = 0; i < NUM_BTN; i++) begin
                shreg_q[i] <= shreg_d[i];
                lcnt_q[i]  <= lcnt_d[i];
            end
        end
    end

    // Pending slots, event output register, arbitration pointer and overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_v_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_type_q  <= EVT_NONE;
            last_q      <= ID_W'(NUM_BTN - 1);
            ovf_q       <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                slot_t_q[i] <= EVT_NONE;
            end
        end else begin
            slot_v_q    <= slot_v_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_type_q  <= evt_type_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                slot_t_q[i] <= slot_t_d[i];
            end
        end
    end

endmodule
